// File: rtl/io_buffer_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// io_arb_pkg
// Shared definitions for the IO buffer write arbiter family: FSM state
// encoding and the default buffer geometry, which is also used wherever the
// IO output buffer itself is instantiated so both sides agree on it.
// ---------------------------------------------------------------------------
package io_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_e;

  // Default buffer data width and requester count
  localparam int unsigned IO_ARB_WIDTH   = 32;
  localparam int unsigned IO_ARB_NUM_REQ = 3;
  localparam int unsigned IO_ARB_SRC_W   = 2;

endpackage : io_arb_pkg

// File: rtl/io_buffer_write_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. The request vector is duplicated to
// 2*N bits and every bit below the pointer is masked off; the lowest
// remaining set bit, folded back modulo N, is the winner. This gives the
// search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 without a wrap mux.
//
// Ports:
//   req     [N-1:0]   request vector
//   ptr     [PW-1:0]  round-robin pointer (highest-priority index)
//   any_req           at least one request bit set
//   win     [PW-1:0]  winning index (0 when any_req is low)
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any_req,
  output logic [PW-1:0] win
);

  logic [2*N-1:0] req_dbl_s;
  logic [2*N-1:0] masked_s;
  logic [PW-1:0]  win_s;

  // Build the double-width masked vector and priority-encode its lowest set bit
  always_comb begin
    req_dbl_s = {req, req};
    masked_s  = '0;
    win_s     = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (i >= int'(ptr)) begin
        masked_s[i] = req_dbl_s[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end
    // Scan downwards so the last hit written is the lowest set bit
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked_s[i]) begin
        win_s = PW'(i % N);
      end else begin
        win_s = win_s;
      end
    end
  end

  assign any_req = |req;
  assign win     = win_s;

endmodule : rr_picker

// File: rtl/io_buffer_write_arbiter.sv
// ---------------------------------------------------------------------------
// io_buffer_write_arbiter
// Shares one IO output buffer register between NUM_REQ writers. A winner is
// picked round-robin in IDLE; the following WRITE cycle presents exactly one
// registered write strobe with the winner's data and a one-cycle ack pulse.
// All outputs are registered; there is no combinational path from req.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (aborts an in-flight write)
//   req         per-requester level request, held until acked
//   req_data    flattened data, slice i = [i*WIDTH +: WIDTH]
//   ack         one-hot, one-cycle pulse for the requester being written
//   buf_we      buffer write enable
//   buf_din     buffer write data (holds its value outside WRITE)
//   busy        high during the WRITE cycle
//   last_src    index of the most recent writer
//   last_valid  at least one write completed since reset
// ---------------------------------------------------------------------------
module io_buffer_write_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = IO_ARB_WIDTH,
  parameter int unsigned NUM_REQ = IO_ARB_NUM_REQ,
  parameter int unsigned SRC_W   = IO_ARB_SRC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     buf_we,
  output logic [WIDTH-1:0]         buf_din,
  output logic                     busy,
  output logic [SRC_W-1:0]         last_src,
  output logic                     last_valid
);

  arb_state_e         state_r;
  arb_state_e         state_nxt_s;
  logic               grant_s;
  logic               any_req_s;
  logic [SRC_W-1:0]   win_s;
  logic [SRC_W-1:0]   ptr_r;
  logic [SRC_W-1:0]   ptr_nxt_s;
  logic [NUM_REQ-1:0] ack_nxt_s;
  logic [WIDTH-1:0]   din_nxt_s;

  logic [NUM_REQ-1:0] ack_r;
  logic               buf_we_r;
  logic [WIDTH-1:0]   buf_din_r;
  logic               busy_r;
  logic [SRC_W-1:0]   last_src_r;
  logic               last_valid_r;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (SRC_W)
  ) u_rr_picker (
    .req     (req),
    .ptr     (ptr_r),
    .any_req (any_req_s),
    .win     (win_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; arbitration only takes effect from IDLE
  always_comb begin
    state_nxt_s = ST_IDLE;
    grant_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_WRITE;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_s     = 1'b0;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_IDLE;
        grant_s     = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_s     = 1'b0;
      end
    endcase
  end

  // Winner decode: one-hot ack, selected data slice and advanced pointer
  always_comb begin
    ack_nxt_s = '0;
    din_nxt_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == SRC_W'(i)) begin
        ack_nxt_s[i] = 1'b1;
        din_nxt_s    = req_data[i*WIDTH +: WIDTH];
      end else begin
        ack_nxt_s[i] = 1'b0;
      end
    end
    if (win_s == SRC_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + SRC_W'(1);
    end
  end

  // Registered outputs and round-robin pointer; strobes last exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r        <= '0;
      buf_we_r     <= 1'b0;
      buf_din_r    <= '0;
      busy_r       <= 1'b0;
      last_src_r   <= '0;
      last_valid_r <= 1'b0;
      ptr_r        <= '0;
    end else begin
      buf_we_r <= grant_s;
      busy_r   <= grant_s;
      if (grant_s) begin
        ack_r        <= ack_nxt_s;
        buf_din_r    <= din_nxt_s;
        last_src_r   <= win_s;
        last_valid_r <= 1'b1;
        ptr_r        <= ptr_nxt_s;
      end else begin
        ack_r <= '0;
      end
    end
  end

  assign ack        = ack_r;
  assign buf_we     = buf_we_r;
  assign buf_din    = buf_din_r;
  assign busy       = busy_r;
  assign last_src   = last_src_r;
  assign last_valid = last_valid_r;

endmodule : io_buffer_write_arbiter

// File: tb/tb_io_buffer_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_buffer_write_arbiter
// Scoreboard bench: a reference arbiter model predicts each grant when the
// requests are driven and queues the expected (source, data); the entry is
// popped and compared when the DUT raises its write strobe. A bench-side
// buffer register models the downstream IO buffer output.
// ---------------------------------------------------------------------------
module tb_io_buffer_write_arbiter;
  import io_arb_pkg::*;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    ack;
  logic            buf_we;
  logic [W-1:0]    buf_din;
  logic            busy;
  logic [SW-1:0]   last_src;
  logic            last_valid;
  logic [W-1:0]    buf_dout;

  typedef struct {
    int          src;
    logic [W-1:0] data;
  } txn_t;

  txn_t          sb_q[$];
  int            n_checks;
  int            n_errors;
  logic          m_write;
  logic          m_next;
  int            m_p;
  logic [SW-1:0] exp_src;
  logic          exp_lv;
  logic [W-1:0]  exp_din;
  logic [W-1:0]  exp_dout;
  logic [N-1:0]  persist;
  int            waits[N];

  io_buffer_write_arbiter #(
    .WIDTH   (W),
    .NUM_REQ (N),
    .SRC_W   (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .buf_we     (buf_we),
    .buf_din    (buf_din),
    .busy       (busy),
    .last_src   (last_src),
    .last_valid (last_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream IO buffer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_dout <= '0;
    else if (buf_we) buf_dout <= buf_din;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_write  = 1'b0;
    m_next   = 1'b0;
    m_p      = 0;
    exp_src  = '0;
    exp_lv   = 1'b0;
    exp_din  = '0;
    exp_dout = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
    req[i] = 1'b1;
  endtask

  // Predict what the DUT does at the coming edge with the requests now driven
  task automatic predict();
    int w;
    txn_t t;
    m_next = 1'b0;
    if (!m_write && rst_n && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_p + k) % N]) w = (m_p + k) % N;
      end
      t.src  = w;
      t.data = req_data[w*W +: W];
      sb_q.push_back(t);
      m_p    = (w + 1) % N;
      m_next = 1'b1;
    end
  endtask

  // Advance one cycle, compare outputs, and let the acked requester react
  task automatic sample();
    txn_t t;
    logic [N-1:0] onehot;
    @(posedge clk);
    #1;
    m_write = m_next;
    chk("buf_dout", buf_dout, exp_dout);
    chk("buf_we", buf_we, m_write);
    chk("busy", busy, m_write);
    if (m_write && sb_q.size() > 0) begin
      t = sb_q.pop_front();
      onehot = '0;
      onehot[t.src] = 1'b1;
      chk("ack", ack, onehot);
      chk("buf_din", buf_din, t.data);
      exp_src  = SW'(t.src);
      exp_lv   = 1'b1;
      exp_din  = t.data;
      exp_dout = t.data;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          chk("starve", waits[i] <= N, 1);
          waits[i] = 0;
        end else if (req[i]) begin
          waits[i]++;
        end
      end
      if (!persist[t.src]) req[t.src] = 1'b0;
    end else begin
      chk("ack_idle", ack, 64'd0);
      chk("buf_din_hold", buf_din, exp_din);
    end
    chk("last_src", last_src, exp_src);
    chk("last_valid", last_valid, exp_lv);
  endtask

  task automatic tick();
    predict();
    sample();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    persist  = '0;
    model_reset();

    // Reset held for three cycles, then idle with no requests
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Contention from reset: grants 0, 1, 2
    set_req(0, 32'h1111_0000);
    set_req(1, 32'h2222_0001);
    set_req(2, 32'h3333_0002);
    repeat (7) tick();

    // Fairness / wrap: p = 0, req 101 -> 0 then 2
    set_req(0, 32'h0A0A_0A0A);
    set_req(2, 32'h0C0C_0C0C);
    repeat (5) tick();

    // Single request
    set_req(1, 32'hDEAD_BEEF);
    repeat (4) tick();

    // Persistent requesters 0 and 1: alternation
    persist = 3'b011;
    set_req(0, 32'hCAFE_0000);
    set_req(1, 32'hCAFE_0001);
    repeat (10) tick();
    persist = '0;
    req     = '0;
    repeat (2) tick();

    // Random traffic with occasional idle-time withdrawals
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(2) == 0) begin
          persist[i] = ($urandom_range(5) == 0);
          set_req(i, $urandom);
        end else if (req[i] && !m_write && !persist[i] && $urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    persist = '0;
    req     = '0;
    repeat (3) tick();

    // Reset during WRITE: strobe and ack drop immediately, pointer back to 0
    set_req(1, 32'hA5A5_0001);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_buf_we", buf_we, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_valid", last_valid, 0);
    chk("rst_buf_din", buf_din, 0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 32'hB0B0_0001);
    set_req(2, 32'hB0B0_0002);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_io_buffer_write_arbiter
